// File: rtl/bram_req_bridge.sv
// rtl/bram_req_bridge.sv - byte-addressed load/store bridge to a single-port block RAM with in-order response FIFO
module bram_req_bridge #(
  parameter int DEPTH      = 65536,
  parameter int ADDR_W     = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [1:0]               req_size,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     resp_wr,
  output logic [$clog2(DEPTH)-1:0] bram_addr,
  output logic [31:0]              bram_din,
  output logic [3:0]               bram_we,
  input  logic [31:0]              bram_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);

  // Address bits above the RAM's word range are deliberately dropped so accesses alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_W-1:AW+2];

  // In-flight stage: one request whose RAM read is underway
  logic       infl_vld_q, infl_vld_d;
  logic       infl_wr_q, infl_wr_d;
  logic       infl_err_q, infl_err_d;
  logic [1:0] infl_size_q, infl_size_d;
  logic [1:0] infl_off_q, infl_off_d;

  // Response FIFO
  logic [31:0]   fifo_rdata_q [RESP_DEPTH];
  logic          fifo_err_q   [RESP_DEPTH];
  logic          fifo_wr_q    [RESP_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        accept;
  logic        req_err;
  logic [3:0]  we_mask;
  logic [31:0] din_rep;
  logic        push;
  logic        pop;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Credit covers both the in-flight entry and queued responses; a same-cycle pop is not counted.
  assign req_ready = !rst && ((count_q + CW'(infl_vld_q)) < FULL);
  assign accept    = req_valid && req_ready;

  // Decode size/offset into replicated write data, byte lanes and the misalignment flag
  always_comb begin
    req_err = 1'b0;
    we_mask = 4'b0000;
    din_rep = req_wdata;
    case (req_size)
      2'd0: begin
        din_rep = {4{req_wdata[7:0]}};
        we_mask = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        din_rep = {2{req_wdata[15:0]}};
        we_mask = 4'b0011 << req_addr[1:0];
        req_err = req_addr[0];
      end
      2'd2: begin
        we_mask = 4'b1111;
        req_err = |req_addr[1:0];
      end
      default: req_err = 1'b1;
    endcase
  end

  assign bram_addr = req_addr[AW+1:2];
  assign bram_din  = din_rep;
  assign bram_we   = (accept && req_wr && !req_err) ? we_mask : 4'b0000;

  // Capture the accepted request's attributes for use when RAM data arrives next cycle
  always_comb begin
    infl_vld_d  = accept;
    infl_wr_d   = infl_wr_q;
    infl_err_d  = infl_err_q;
    infl_size_d = infl_size_q;
    infl_off_d  = infl_off_q;
    if (accept) begin
      infl_wr_d   = req_wr;
      infl_err_d  = req_err;
      infl_size_d = req_size;
      infl_off_d  = req_addr[1:0];
    end
  end

  // In-flight stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_vld_q  <= 1'b0;
      infl_wr_q   <= 1'b0;
      infl_err_q  <= 1'b0;
      infl_size_q <= 2'd0;
      infl_off_q  <= 2'd0;
    end else begin
      infl_vld_q  <= infl_vld_d;
      infl_wr_q   <= infl_wr_d;
      infl_err_q  <= infl_err_d;
      infl_size_q <= infl_size_d;
      infl_off_q  <= infl_off_d;
    end
  end

  // Align the RAM word to the LSB and trim to the access size; stores and errors carry zero
  always_comb begin
    shifted   = bram_dout >> {infl_off_q, 3'b000};
    load_data = shifted;
    case (infl_size_q)
      2'd0:    load_data = {24'd0, shifted[7:0]};
      2'd1:    load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    if (infl_wr_q || infl_err_q) begin
      load_data = 32'd0;
    end
  end

  assign push = infl_vld_q;
  assign pop  = resp_valid && resp_ready;

  // Next-state for FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FIFO pointer/occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only observed through a valid head, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rdata_q[wr_ptr_q] <= load_data;
      fifo_err_q[wr_ptr_q]   <= infl_err_q;
      fifo_wr_q[wr_ptr_q]    <= infl_wr_q;
    end
  end

  assign resp_valid = (count_q != '0);
  assign resp_rdata = resp_valid ? fifo_rdata_q[rd_ptr_q] : 32'd0;
  assign resp_err   = resp_valid ? fifo_err_q[rd_ptr_q]   : 1'b0;
  assign resp_wr    = resp_valid ? fifo_wr_q[rd_ptr_q]    : 1'b0;

  no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push && (count_q == FULL)));

endmodule
